// File: rtl/ca_rule_scheduler.sv
// Frame-level seed/advance/hold controller for the 1-D cellular-automaton VGA datapath.
// Buttons are sampled once per frame; rule and colour are chosen per scrolling band of cell rows.
module ca_rule_scheduler #(
  parameter int unsigned BAND_ROWS = 32,
  parameter int unsigned NUM_RULES = 8,
  parameter int unsigned SCROLL_W  = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       row_tick,
  input  logic       btn_pause,
  input  logic       btn_step,
  input  logic       btn_next,
  input  logic       btn_reseed,
  input  logic       override_en,
  input  logic [7:0] rule_override,
  output logic       seed,
  output logic       advance,
  output logic [7:0] rule,
  output logic [5:0] rule_color,
  output logic       paused
);

  localparam int unsigned BAND_SH = (BAND_ROWS > 1) ? $clog2(BAND_ROWS) : 0;
  localparam int unsigned RIDX_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam logic [7:0]  RULE0   = 8'd30;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SEED,
    ST_RUN,
    ST_PAUSE,
    ST_STEP
  } state_t;

  function automatic logic [7:0] rule_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    rule_lut = 8'd30;
      3'd1:    rule_lut = 8'd110;
      3'd2:    rule_lut = 8'd22;
      3'd3:    rule_lut = 8'd73;
      3'd4:    rule_lut = 8'd90;
      3'd5:    rule_lut = 8'd146;
      3'd6:    rule_lut = 8'd105;
      default: rule_lut = 8'd102;
    endcase
  endfunction

  // bit order: {reseed, next, step, pause}
  logic [3:0] btn_raw, sync1, sync2, sample, press;

  state_t              state, state_nx;
  logic                seed_nx, advance_nx, paused_nx;
  logic [SCROLL_W-1:0] scroll, scroll_nx, row_idx, row_nx, pos, band;
  logic [RIDX_W-1:0]   base, base_nx, ridx;
  logic [7:0]          rule_sel;

  assign btn_raw = {btn_reseed, btn_next, btn_step, btn_pause};
  assign press   = sync2 & ~sample;

  // Next-state, frame-level outputs and rule selection
  always_comb begin
    state_nx   = state;
    seed_nx    = seed;
    advance_nx = advance;
    paused_nx  = paused;
    scroll_nx  = scroll;
    base_nx    = base;
    row_nx     = row_idx;

    if (frame_start) begin
      row_nx = '0;
      if (press[2]) base_nx = (NUM_RULES > 1) ? RIDX_W'(base + RIDX_W'(1)) : '0;

      unique case (state)
        ST_INIT:  state_nx = ST_SEED;
        ST_SEED:  state_nx = ST_RUN;
        ST_RUN:   state_nx = press[0] ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_nx = press[0] ? ST_RUN : (press[1] ? ST_STEP : ST_PAUSE);
        ST_STEP:  state_nx = ST_PAUSE;
        default:  state_nx = ST_INIT;
      endcase
      if (state != ST_INIT && press[3]) state_nx = ST_SEED;

      if (state_nx == ST_SEED)
        scroll_nx = '0;
      else if (state == ST_RUN || state == ST_STEP)
        scroll_nx = SCROLL_W'(scroll + SCROLL_W'(1));

      seed_nx    = (state_nx == ST_SEED);
      advance_nx = (state_nx == ST_RUN) || (state_nx == ST_STEP);
      paused_nx  = (state_nx == ST_PAUSE) || (state_nx == ST_STEP);
    end else if (row_tick) begin
      row_nx = SCROLL_W'(row_idx + SCROLL_W'(1));
    end

    pos      = SCROLL_W'(scroll_nx + row_nx);
    band     = pos >> BAND_SH;
    ridx     = (NUM_RULES > 1) ? RIDX_W'(RIDX_W'(band) + base_nx) : '0;
    rule_sel = override_en ? rule_override : rule_lut(3'(ridx));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sample     <= '0;
      state      <= ST_INIT;
      seed       <= 1'b0;
      advance    <= 1'b0;
      paused     <= 1'b0;
      scroll     <= '0;
      base       <= '0;
      row_idx    <= '0;
      rule       <= RULE0;
      rule_color <= RULE0[6:1];
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      if (frame_start) sample <= sync2;
      state   <= state_nx;
      seed    <= seed_nx;
      advance <= advance_nx;
      paused  <= paused_nx;
      scroll  <= scroll_nx;
      base    <= base_nx;
      row_idx <= row_nx;
      if (frame_start || row_tick) begin
        rule       <= rule_sel;
        rule_color <= rule_sel[6:1];
      end
    end
  end

endmodule

// File: doc/ca_rule_scheduler.md
Name: ca_rule_scheduler

Overview:
Frame-level controller for the 1-D cellular-automaton VGA datapath. It decides, per frame, whether the datapath seeds, advances or holds the automaton, and supplies the active 8-bit rule and 6-bit colour per band of cell rows. Band positions scroll with the pattern. Button inputs are sampled once per frame, which debounces them, and each press becomes a single state change applied at the next frame boundary.

Parameters:
BAND_ROWS, 32, cell rows per rule band; power of two, 1..256.
NUM_RULES, 8, rule-table entries; power of two.
SCROLL_W, 11, width of the scroll-phase counter; wraps modulo 2^SCROLL_W.

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at pix_x==0, pix_y==0
row_tick  in  1  one-cycle pulse at pix_x==0 of the first pixel line of each cell row, excluding row 0
btn_pause  in  1  raw button: toggles run/pause
btn_step  in  1  raw button: advances one frame while paused
btn_next  in  1  raw button: rotates the rule-table base by +1
btn_reseed  in  1  raw button: re-seeds the automaton
override_en  in  1  when 1, rule_override replaces the table output
rule_override  in  8  forced rule
seed  out  1  level held for a whole frame: datapath loads the seed row
advance  out  1  level held for a whole frame: datapath commits next_cells
rule  out  8  active rule for the current cell row
rule_color  out  6  {R[1:0],G[1:0],B[1:0]}; equals rule[6:1] of the active rule
paused  out  1  1 in PAUSE and STEP

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on reset.
- Reset values: state=INIT, seed=0, advance=0, paused=0, scroll=0, base=0, row_idx=0, rule=table[0], rule_color=table[0][6:1]. All pending-press flags and button history cleared.
- Rule table contents: 30, 110, 22, 73, 90, 146, 105, 102. Entries beyond 8 repeat the table modulo 8.
- Button sampling:
  - 2-flop synchroniser on each button.
  - The synchronised level is sampled only on frame_start.
  - A press is a 0→1 change between consecutive samples.
  - A button held high produces exactly one press.
- FSM states: INIT, SEED, RUN, PAUSE, STEP. Transitions are evaluated only on frame_start; outputs update on the same clk edge.
  - INIT → SEED unconditionally.
  - SEED → RUN.
  - RUN → PAUSE on a pause press.
  - PAUSE → RUN on a pause press.
  - PAUSE → STEP on a step press.
  - STEP → PAUSE.
  - A reseed press in any state except INIT → SEED. It has priority over pause and step presses in the same sample.
  - Simultaneous pause and step presses in PAUSE → RUN.
  - A step press in RUN is ignored.
- Outputs per state:
  - seed=1 only in SEED.
  - advance=1 in RUN and STEP.
  - paused=1 in PAUSE and STEP.
  - All three are constant between frame_start pulses.
- Scroll:
  - On frame_start, if the state being left was RUN or STEP, scroll increments by 1.
  - Entering SEED clears scroll to 0.
- Base: a next press increments base modulo NUM_RULES on frame_start, in any state.
- Row indexing:
  - frame_start sets row_idx=0.
  - row_tick increments row_idx.
  - If frame_start and row_tick coincide, frame_start wins and row_idx=0.
- Rule index: ((scroll + row_idx) / BAND_ROWS + base) mod NUM_RULES.
- rule and rule_color:
  - Registered; updated on the clk edge that consumes frame_start or row_tick, giving 1-cycle latency.
  - Otherwise held.
  - override_en is sampled at the same edges. When set, rule=rule_override and rule_color=rule_override[6:1].
- Arithmetic: scroll + row_idx is computed at SCROLL_W bits and wraps. No saturation anywhere.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. The next frame_start enters SEED.

Test Plan:
- Reset, then 3 frame_starts → frame 1 seed=1/advance=0; frames 2–3 seed=0/advance=1; scroll=1 after frame 3 begins.
- RUN, row_ticks with base=0, scroll=0 → rows 0–31 rule=30/color=0x0F, row 32 rule=110/color=0x37, row 256 (wrapped index 0) rule=30.
- btn_pause held high across 5 frame_starts → exactly one RUN→PAUSE; advance=0 and paused=1 from the next frame; scroll frozen.
- In PAUSE, press btn_step once → exactly one frame with advance=1, then PAUSE; scroll +1.
- btn_reseed and btn_pause pressed in the same sample while in RUN → SEED frame, seed=1, scroll=0, then RUN.
- override_en=1, rule_override=0xB6 → rule=0xB6, color=0x1B at the next row_tick. btn_next press → base=1, row 0 rule=110 after override is released.
